// File: rtl/axi4_lite_bram_ctrl.sv
// AXI4-Lite slave bridging single-beat reads and writes onto a byte-enabled,
// one-cycle-latency BRAM port. One transaction in flight; read/write ties alternate.
module axi4_lite_bram_ctrl #(
    parameter int                ADDR_W      = 32,
    parameter int                DATA_W      = 32,
    parameter int                BRAM_ADDR_W = 10,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [ADDR_W-1:0]      s_awaddr,
    input  logic                   s_awvalid,
    output logic                   s_awready,
    input  logic [DATA_W-1:0]      s_wdata,
    input  logic [3:0]             s_wstrb,
    input  logic                   s_wvalid,
    output logic                   s_wready,
    output logic [1:0]             s_bresp,
    output logic                   s_bvalid,
    input  logic                   s_bready,
    input  logic [ADDR_W-1:0]      s_araddr,
    input  logic                   s_arvalid,
    output logic                   s_arready,
    output logic [DATA_W-1:0]      s_rdata,
    output logic [1:0]             s_rresp,
    output logic                   s_rvalid,
    input  logic                   s_rready,
    output logic [3:0]             bram_we,
    output logic [BRAM_ADDR_W-1:0] bram_addr,
    output logic [DATA_W-1:0]      bram_din,
    input  logic [DATA_W-1:0]      bram_dout
);

    typedef enum logic [2:0] {
        IDLE,
        WR_MEM,
        WR_RESP,
        RD_MEM,
        RD_WAIT,
        RD_RESP
    } state_t;

    localparam logic [1:0]        RESP_OKAY   = 2'b00;
    localparam logic [1:0]        RESP_DECERR = 2'b11;
    localparam logic [ADDR_W-1:0] WIN_MASK    =
        ~((ADDR_W'(1) << (BRAM_ADDR_W + 2)) - ADDR_W'(1));

    state_t     state;
    state_t     state_n;
    logic       last_wr;
    logic       addr_ok;
    logic [3:0] we_q;
    logic       wr_req;
    logic       rd_req;
    logic       grant_wr;
    logic       grant_rd;

    function automatic logic in_window(input logic [ADDR_W-1:0] a);
        return (a & WIN_MASK) == BASE_ADDR;
    endfunction

    assign wr_req   = s_awvalid & s_wvalid;
    assign rd_req   = s_arvalid;
    assign grant_wr = (state == IDLE) & wr_req & (~rd_req | ~last_wr);
    assign grant_rd = (state == IDLE) & rd_req & (~wr_req | last_wr);

    assign s_awready = grant_wr;
    assign s_wready  = grant_wr;
    assign s_arready = grant_rd;

    // Gated by rst so a write caught by reset in WR_MEM never reaches the array.
    assign bram_we = (state == WR_MEM && !rst) ? we_q : 4'b0000;

    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (grant_wr) begin
                    state_n = WR_MEM;
                end else if (grant_rd) begin
                    state_n = RD_MEM;
                end
            end
            WR_MEM:  state_n = WR_RESP;
            WR_RESP: if (s_bready) state_n = IDLE;
            RD_MEM:  state_n = RD_WAIT;
            RD_WAIT: state_n = RD_RESP;
            RD_RESP: if (s_rready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            last_wr   <= 1'b0;
            addr_ok   <= 1'b0;
            we_q      <= 4'b0000;
            bram_addr <= '0;
            bram_din  <= '0;
            s_bvalid  <= 1'b0;
            s_bresp   <= RESP_OKAY;
            s_rvalid  <= 1'b0;
            s_rdata   <= '0;
            s_rresp   <= RESP_OKAY;
        end else begin
            state <= state_n;
            case (state)
                IDLE: begin
                    // last_wr only moves on a contested grant, so ties alternate.
                    if (grant_wr) begin
                        bram_addr <= s_awaddr[BRAM_ADDR_W+1:2];
                        bram_din  <= s_wdata;
                        addr_ok   <= in_window(s_awaddr);
                        we_q      <= in_window(s_awaddr) ? s_wstrb : 4'b0000;
                        if (rd_req) last_wr <= 1'b1;
                    end else if (grant_rd) begin
                        bram_addr <= s_araddr[BRAM_ADDR_W+1:2];
                        addr_ok   <= in_window(s_araddr);
                        if (wr_req) last_wr <= 1'b0;
                    end
                end
                WR_MEM: begin
                    s_bvalid <= 1'b1;
                    s_bresp  <= addr_ok ? RESP_OKAY : RESP_DECERR;
                end
                WR_RESP: begin
                    if (s_bready) s_bvalid <= 1'b0;
                end
                RD_WAIT: begin
                    s_rvalid <= 1'b1;
                    s_rdata  <= addr_ok ? bram_dout : '0;
                    s_rresp  <= addr_ok ? RESP_OKAY : RESP_DECERR;
                end
                RD_RESP: begin
                    if (s_rready) s_rvalid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_axi4_lite_bram_ctrl.sv
// Bench for axi4_lite_bram_ctrl: directed cases plus random traffic scored
// against a word-array memory model with byte-strobe merge and window decode.
module tb_axi4_lite_bram_ctrl;

    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam logic [31:0] WIN  = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_clr;
    logic [31:0] s_awaddr, s_wdata, s_araddr;
    logic [3:0]  s_wstrb;
    logic        s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready;
    logic        s_awready, s_wready, s_bvalid, s_arready, s_rvalid;
    logic [1:0]  s_bresp, s_rresp;
    logic [31:0] s_rdata;
    logic [3:0]  bram_we;
    logic [9:0]  bram_addr;
    logic [31:0] bram_din;
    logic [31:0] bram_dout;

    logic [31:0] bram_mem [0:1023];
    logic [31:0] ref_mem  [0:1023];
    int          n_checks = 0;
    int          n_pass   = 0;

    always #5 clk = ~clk;

    axi4_lite_bram_ctrl #(
        .ADDR_W(32), .DATA_W(32), .BRAM_ADDR_W(10), .BASE_ADDR(BASE)
    ) dut (
        .clk(clk), .rst(rst),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .bram_we(bram_we), .bram_addr(bram_addr), .bram_din(bram_din), .bram_dout(bram_dout)
    );

    // BRAM stand-in: byte-enabled synchronous write, registered read.
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 1024; i++) bram_mem[i] <= 32'h0;
            bram_dout <= 32'h0;
        end else begin
            for (int b = 0; b < 4; b++)
                if (bram_we[b]) bram_mem[bram_addr][8*b +: 8] <= bram_din[8*b +: 8];
            bram_dout <= bram_mem[bram_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic bit ref_in_range(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - BASE;
        return off < WIN;
    endfunction

    function automatic logic [9:0] ref_idx(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - BASE;
        return off[11:2];
    endfunction

    task automatic ref_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        logic [9:0] idx;
        idx = ref_idx(addr);
        if (ref_in_range(addr))
            for (int b = 0; b < 4; b++)
                if (strb[b]) ref_mem[idx][8*b +: 8] = data[8*b +: 8];
    endtask

    function automatic logic [31:0] ref_read(input logic [31:0] addr);
        return ref_in_range(addr) ? ref_mem[ref_idx(addr)] : 32'h0;
    endfunction

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        bit got;
        bit ok;
        ok = ref_in_range(addr);
        @(negedge clk);
        s_awaddr = addr; s_wdata = data; s_wstrb = strb;
        s_awvalid = 1'b1; s_wvalid = 1'b1; s_bready = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (s_awready && s_wready) begin got = 1'b1; break; end
            @(negedge clk);
        end
        check("wr_grant", 32'(got), 32'd1);
        if (!got) begin
            s_awvalid = 1'b0; s_wvalid = 1'b0;
            return;
        end
        @(posedge clk); @(negedge clk);
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        check("wr_we", 32'(bram_we), ok ? 32'(strb) : 32'd0);
        check("wr_addr", 32'(bram_addr), 32'(ref_idx(addr)));
        check("wr_din", bram_din, data);
        @(negedge clk);
        check("wr_bvalid", 32'(s_bvalid), 32'd1);
        check("wr_bresp", 32'(s_bresp), ok ? 32'd0 : 32'd3);
        @(negedge clk);
        check("wr_bvalid_drop", 32'(s_bvalid), 32'd0);
        ref_write(addr, data, strb);
    endtask

    task automatic do_read(input logic [31:0] addr, output logic [31:0] rd);
        bit got;
        bit ok;
        ok = ref_in_range(addr);
        rd = 32'h0;
        @(negedge clk);
        s_araddr = addr; s_arvalid = 1'b1; s_rready = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (s_arready) begin got = 1'b1; break; end
            @(negedge clk);
        end
        check("rd_grant", 32'(got), 32'd1);
        if (!got) begin
            s_arvalid = 1'b0;
            return;
        end
        @(posedge clk); @(negedge clk);
        s_arvalid = 1'b0;
        check("rd_we", 32'(bram_we), 32'd0);
        check("rd_addr", 32'(bram_addr), 32'(ref_idx(addr)));
        @(negedge clk);
        check("rd_rvalid_early", 32'(s_rvalid), 32'd0);
        @(negedge clk);
        check("rd_rvalid", 32'(s_rvalid), 32'd1);
        check("rd_rdata", s_rdata, ref_read(addr));
        check("rd_rresp", 32'(s_rresp), ok ? 32'd0 : 32'd3);
        rd = s_rdata;
        @(negedge clk);
        check("rd_rvalid_drop", 32'(s_rvalid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic [31:0] held;
        logic [31:0] a;
        for (int i = 0; i < 1024; i++) ref_mem[i] = 32'h0;
        rst = 1'b1; mem_clr = 1'b1;
        s_awaddr = '0; s_wdata = '0; s_wstrb = '0; s_araddr = '0;
        s_awvalid = 0; s_wvalid = 0; s_bready = 0; s_arvalid = 0; s_rready = 0;
        repeat (3) @(negedge clk);
        check("rst_bvalid", 32'(s_bvalid), 32'd0);
        check("rst_rvalid", 32'(s_rvalid), 32'd0);
        check("rst_we", 32'(bram_we), 32'd0);
        check("rst_addr", 32'(bram_addr), 32'd0);
        check("rst_din", bram_din, 32'd0);
        check("rst_rdata", s_rdata, 32'd0);
        check("rst_resp", 32'({s_bresp, s_rresp}), 32'd0);
        rst = 1'b0; mem_clr = 1'b0;

        // Tie right after reset: write first, then the waiting read.
        @(negedge clk);
        s_awaddr = 32'h40; s_wdata = 32'hCAFEF00D; s_wstrb = 4'hF; s_awvalid = 1; s_wvalid = 1;
        s_araddr = 32'h40; s_arvalid = 1; s_bready = 1; s_rready = 1;
        #1;
        check("tie1_aw", 32'(s_awready), 32'd1);
        check("tie1_ar", 32'(s_arready), 32'd0);
        @(posedge clk); @(negedge clk);
        s_awvalid = 0; s_wvalid = 0;
        check("tie1_we", 32'(bram_we), 32'hF);
        ref_write(32'h40, 32'hCAFEF00D, 4'hF);
        @(negedge clk);
        check("tie1_bvalid", 32'(s_bvalid), 32'd1);
        @(negedge clk); #1;
        check("tie1_ar_next", 32'(s_arready), 32'd1);
        @(posedge clk); @(negedge clk);
        s_arvalid = 0;
        @(negedge clk); @(negedge clk);
        check("tie1_rvalid", 32'(s_rvalid), 32'd1);
        check("tie1_rdata", s_rdata, ref_read(32'h40));
        @(negedge clk);

        // Second tie: read goes first this time.
        s_awaddr = 32'h44; s_wdata = 32'h0F1E2D3C; s_wstrb = 4'hF; s_awvalid = 1; s_wvalid = 1;
        s_araddr = 32'h40; s_arvalid = 1;
        #1;
        check("tie2_ar", 32'(s_arready), 32'd1);
        check("tie2_aw", 32'(s_awready), 32'd0);
        @(posedge clk); @(negedge clk);
        s_arvalid = 0;
        @(negedge clk); @(negedge clk);
        check("tie2_rvalid", 32'(s_rvalid), 32'd1);
        check("tie2_rdata", s_rdata, 32'hCAFEF00D);
        @(negedge clk); #1;
        check("tie2_aw_next", 32'(s_awready), 32'd1);
        @(posedge clk); @(negedge clk);
        s_awvalid = 0; s_wvalid = 0;
        check("tie2_we", 32'(bram_we), 32'hF);
        ref_write(32'h44, 32'h0F1E2D3C, 4'hF);
        @(negedge clk);
        check("tie2_bvalid", 32'(s_bvalid), 32'd1);

        // Write/read and byte strobes.
        do_write(32'h10, 32'hDEADBEEF, 4'hF);
        do_read(32'h10, rd);
        check("wr_rd_deadbeef", rd, 32'hDEADBEEF);
        do_write(32'h10, 32'h11223344, 4'hF);
        do_write(32'h10, 32'hAABBCCDD, 4'b0101);
        do_read(32'h10, rd);
        check("strb_merge", rd, 32'h11BB33DD);

        // Out of window.
        do_write(BASE + 32'h1000, 32'h55AA55AA, 4'hF);
        do_read(BASE + 32'h1000, rd);
        check("oor_rdata", rd, 32'h0);
        do_read(32'h0, rd);

        // Read response stalled for five cycles with a write waiting.
        do_write(32'h80, 32'h0BADF00D, 4'hF);
        @(negedge clk);
        s_araddr = 32'h80; s_arvalid = 1; s_rready = 0;
        #1;
        check("bp_ar", 32'(s_arready), 32'd1);
        @(posedge clk); @(negedge clk);
        s_arvalid = 0;
        s_awaddr = 32'h84; s_wdata = 32'h600DCAFE; s_wstrb = 4'hF; s_awvalid = 1; s_wvalid = 1; s_bready = 1;
        @(negedge clk); @(negedge clk);
        held = s_rdata;
        check("bp_rdata", held, 32'h0BADF00D);
        for (int i = 0; i < 5; i++) begin
            #1;
            check("bp_rvalid_hold", 32'(s_rvalid), 32'd1);
            check("bp_rdata_hold", s_rdata, held);
            check("bp_aw_blocked", 32'({s_awready, s_arready}), 32'd0);
            @(negedge clk);
        end
        s_rready = 1;
        #1;
        check("bp_aw_pre_r", 32'(s_awready), 32'd0);
        @(posedge clk); @(negedge clk); #1;
        check("bp_rvalid_drop", 32'(s_rvalid), 32'd0);
        check("bp_aw_after", 32'(s_awready), 32'd1);
        @(posedge clk); @(negedge clk);
        s_awvalid = 0; s_wvalid = 0;
        check("bp_we", 32'(bram_we), 32'hF);
        ref_write(32'h84, 32'h600DCAFE, 4'hF);
        @(negedge clk);
        check("bp_bvalid", 32'(s_bvalid), 32'd1);
        do_read(32'h84, rd);

        // Random traffic against the memory model.
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 7) == 0) a = $urandom | 32'h0000_1000;
            else a = BASE + 32'($urandom_range(0, 4095));
            if ($urandom_range(0, 1) == 1)
                do_write(a, $urandom, 4'($urandom_range(0, 15)));
            else
                do_read(a, rd);
        end

        // Reset while the write sits in WR_MEM.
        do_write(32'h20, 32'h12345678, 4'hF);
        @(negedge clk);
        s_awaddr = 32'h20; s_wdata = 32'hFFFFFFFF; s_wstrb = 4'hF; s_awvalid = 1; s_wvalid = 1; s_bready = 1;
        #1;
        check("rst_mid_grant", 32'(s_awready), 32'd1);
        @(posedge clk); @(negedge clk);
        s_awvalid = 0; s_wvalid = 0;
        rst = 1'b1;
        #1;
        check("rst_mid_we_now", 32'(bram_we), 32'd0);
        @(negedge clk);
        check("rst_mid_we", 32'(bram_we), 32'd0);
        check("rst_mid_bvalid", 32'(s_bvalid), 32'd0);
        check("rst_mid_din", bram_din, 32'd0);
        rst = 1'b0;
        do_read(32'h20, rd);
        check("rst_mid_word", rd, 32'h12345678);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
